// File: rtl/rv32_pkg.sv
// Shared RV32I decode constants and memory-stage FSM state type.
package rv32_pkg;

  // Major opcodes, instr[6:2]
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;

  // Load/store width encodings, instr[14:12]
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // addi x0,x0,0 -- bubble written to writeback when nothing retires
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a load response and extends it.
module load_align
  import rv32_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;
  assign shifted = rdata_i >> {off_i, 3'b000};

  // Select width and extension by funct3; undefined encodings read as zero
  always_comb begin
    data_o = 32'h0;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = shifted;
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/stage4.sv
// RV32I memory stage: issues loads/stores over a valid/ready channel,
// waits for variable-latency read data, and registers results for writeback.
module stage4
  import rv32_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_3,
  input  logic [31:0] alu_3,
  input  logic [31:0] rs2data_3,
  input  logic [31:0] csrdata_3,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        misalign_o,
  output logic [31:0] instr_4,
  output logic [31:0] data_4,
  output logic [31:0] csrdata_4
);

  mem_state_t  state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] data_q, data_d;
  logic [31:0] csr_q, csr_d;
  logic        mis_q, mis_d;

  logic [4:0]  opcode;
  logic [2:0]  funct3;
  logic [1:0]  off;
  logic        is_load, is_store, is_mem, is_half, is_word, misal, mem_ok;
  logic        retire_alu, retire_load, drop;
  logic [3:0]  st_be;
  logic [31:0] st_wdata, ld_data;

  assign opcode   = instr_3[6:2];
  assign funct3   = instr_3[14:12];
  assign off      = alu_3[1:0];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign is_mem   = is_load | is_store;
  // lhu only exists as a load; a store with funct3=101 is not treated as a half
  assign is_half  = (funct3 == F3_H) | (is_load & (funct3 == F3_HU));
  assign is_word  = (funct3 == F3_W);
  assign misal    = (is_half & off[0]) | (is_word & (off != 2'b00));
  assign mem_ok   = is_mem & ~misal;

  // Store byte enables and lane-replicated write data
  always_comb begin
    st_be    = 4'b0000;
    st_wdata = 32'h0;
    case (funct3)
      F3_B: begin
        st_be    = 4'b0001 << off;
        st_wdata = {4{rs2data_3[7:0]}};
      end
      F3_H: begin
        st_be    = 4'b0011 << off;
        st_wdata = {2{rs2data_3[15:0]}};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = rs2data_3;
      end
      default: begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
      end
    endcase
  end

  // Address/lanes come straight from stage3, which upstream holds while stalled
  assign dmem_addr  = {alu_3[31:2], 2'b00};
  assign dmem_we    = is_store;
  assign dmem_be    = is_store ? st_be : 4'b1111;
  assign dmem_wdata = is_store ? st_wdata : 32'h0;

  load_align u_load_align (
    .rdata_i  (dmem_rdata),
    .off_i    (off),
    .funct3_i (funct3),
    .data_o   (ld_data)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (mem_ok) begin
        if (!dmem_ready)  state_d = REQ;
        else if (is_load) state_d = WAIT;
      end
      REQ:  if (dmem_ready) state_d = is_load ? WAIT : IDLE;
      WAIT: if (dmem_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: request, stall and retire strobes.
  // A store accepted out of REQ retires that cycle, so stall drops with it;
  // otherwise upstream would hold and re-issue the same store.
  always_comb begin
    dmem_req    = 1'b0;
    stall_o     = 1'b0;
    retire_alu  = 1'b0;
    retire_load = 1'b0;
    drop        = 1'b0;
    case (state_q)
      IDLE: begin
        dmem_req   = mem_ok;
        stall_o    = mem_ok & ~(is_store & dmem_ready);
        retire_alu = ~is_mem | (mem_ok & is_store & dmem_ready);
        drop       = is_mem & misal;
      end
      REQ: begin
        dmem_req   = 1'b1;
        stall_o    = ~(is_store & dmem_ready);
        retire_alu = is_store & dmem_ready;
      end
      WAIT: begin
        stall_o     = ~dmem_rvalid;
        retire_load = dmem_rvalid;
      end
      default: ;
    endcase
  end

  // Stage register next values: bubble unless something retires
  always_comb begin
    instr_d = NOP_INSTR;
    data_d  = data_q;
    csr_d   = csr_q;
    mis_d   = drop;
    if (retire_alu) begin
      instr_d = instr_3;
      data_d  = alu_3;
      csr_d   = csrdata_3;
    end else if (retire_load) begin
      instr_d = instr_3;
      data_d  = ld_data;
      csr_d   = csrdata_3;
    end
  end

  // Stage register to writeback
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= NOP_INSTR;
      data_q  <= 32'h0;
      csr_q   <= 32'h0;
      mis_q   <= 1'b0;
    end else begin
      instr_q <= instr_d;
      data_q  <= data_d;
      csr_q   <= csr_d;
      mis_q   <= mis_d;
    end
  end

  assign instr_4    = instr_q;
  assign data_4     = data_q;
  assign csrdata_4  = csr_q;
  assign misalign_o = mis_q;

endmodule

// File: tb/tb_stage4.sv
// Directed bench for the memory stage: reset, pass-through, loads, stores,
// backpressure and misalignment.
module tb_stage4;

  localparam logic [31:0] NOP  = 32'h00000013;
  localparam logic [31:0] ADDI = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] LB   = 32'h00008103; // lb  x2,0(x1)
  localparam logic [31:0] LHU  = 32'h0000D103; // lhu x2,0(x1)
  localparam logic [31:0] LW   = 32'h0000A103; // lw  x2,0(x1)
  localparam logic [31:0] SB   = 32'h00208023; // sb  x2,0(x1)
  localparam logic [31:0] SH   = 32'h00209023; // sh  x2,0(x1)

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_3, alu_3, rs2data_3, csrdata_3;
  logic        stall_o, dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        misalign_o;
  logic [31:0] instr_4, data_4, csrdata_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stage4 dut (
    .clk(clk), .reset(reset),
    .instr_3(instr_3), .alu_3(alu_3), .rs2data_3(rs2data_3), .csrdata_3(csrdata_3),
    .stall_o(stall_o),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ready(dmem_ready), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .misalign_o(misalign_o),
    .instr_4(instr_4), .data_4(data_4), .csrdata_4(csrdata_4)
  );

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [31:0] csr);
    instr_3 = ins; alu_3 = alu; rs2data_3 = rs2; csrdata_3 = csr;
  endtask

  task automatic test_reset();
    reset = 1'b1; dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    drive(NOP, 0, 0, 0);
    step(); step();
    reset = 1'b0;
    #1;
    n_checks++;
    if ({instr_4, data_4, csrdata_4, misalign_o, dmem_req} !== {NOP, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: instr_4=%h data_4=%h csr=%h mis=%b req=%b", instr_4, data_4, csrdata_4, misalign_o, dmem_req);
    end
    // put something in data_4, then get a load parked in WAIT
    drive(ADDI, 32'h7, 0, 32'h9);
    step();
    drive(LB, 32'h1000, 0, 0); dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0;
    step();
    reset = 1'b1;
    step(); step();
    reset = 1'b0; drive(NOP, 0, 0, 0);
    #1;
    n_checks++;
    if ({instr_4, data_4, csrdata_4, dmem_req, stall_o} !== {NOP, 32'h0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_mid_wait: instr_4=%h data_4=%h csr=%h req=%b stall=%b", instr_4, data_4, csrdata_4, dmem_req, stall_o);
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF;
    step();
    dmem_rvalid = 1'b0;
    n_checks++;
    if ({instr_4, data_4} !== {NOP, 32'h0}) begin
      n_fail++;
      $display("FAIL late_rvalid_ignored: instr_4=%h data_4=%h want %h 0", instr_4, data_4, NOP);
    end
  endtask

  task automatic test_passthru();
    drive(ADDI, 32'h5, 0, 32'hC5);
    #1;
    n_checks++;
    if ({stall_o, dmem_req} !== 2'b00) begin
      n_fail++;
      $display("FAIL passthru_stall: stall=%b req=%b want 0 0", stall_o, dmem_req);
    end
    step();
    drive(NOP, 0, 0, 0);
    n_checks++;
    if ({instr_4, data_4, csrdata_4} !== {ADDI, 32'h5, 32'hC5}) begin
      n_fail++;
      $display("FAIL passthru_regs: got %h %h %h want %h 5 c5", instr_4, data_4, csrdata_4, ADDI);
    end
  endtask

  task automatic test_load_latency();
    int stalls = 0;
    drive(LB, 32'h1002, 0, 32'h11); dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h1000}) begin
      n_fail++;
      $display("FAIL lb_request: req=%b we=%b addr=%h want 1 0 1000", dmem_req, dmem_we, dmem_addr);
    end
    if (stall_o) stalls++;
    step();
    dmem_ready = 1'b0;
    for (int c = 1; c < 3; c++) begin
      #1;
      n_checks++;
      if ({instr_4, dmem_req} !== {NOP, 1'b0}) begin
        n_fail++;
        $display("FAIL lb_wait_cycle%0d: instr_4=%h req=%b want %h 0", c, instr_4, dmem_req, NOP);
      end
      if (stall_o) stalls++;
      step();
    end
    dmem_rvalid = 1'b1; dmem_rdata = 32'h12F04455;
    #1;
    if (stall_o) stalls++;
    n_checks++;
    if (stalls !== 3) begin
      n_fail++;
      $display("FAIL lb_stall_cycles: got %0d want 3", stalls);
    end
    step();
    dmem_rvalid = 1'b0; drive(NOP, 0, 0, 0);
    n_checks++;
    if ({instr_4, data_4, csrdata_4} !== {LB, 32'hFFFFFFF0, 32'h11}) begin
      n_fail++;
      $display("FAIL lb_result: got %h %h %h want %h fffffff0 11", instr_4, data_4, csrdata_4, LB);
    end
  endtask

  task automatic test_store_backpressure();
    drive(SH, 32'h2002, 32'hABCD1234, 32'h22); dmem_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall_o} !==
          {1'b1, 1'b1, 32'h2000, 4'b1100, 32'h12341234, 1'b1}) begin
        n_fail++;
        $display("FAIL sh_held_cycle%0d: req=%b we=%b addr=%h be=%b wdata=%h stall=%b",
                 c, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall_o);
      end
      step();
      n_checks++;
      if (instr_4 !== NOP) begin
        n_fail++;
        $display("FAIL sh_bubble_cycle%0d: instr_4=%h want %h", c, instr_4, NOP);
      end
    end
    dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, dmem_be, dmem_wdata, stall_o} !== {1'b1, 4'b1100, 32'h12341234, 1'b0}) begin
      n_fail++;
      $display("FAIL sh_accept: req=%b be=%b wdata=%h stall=%b want 1 1100 12341234 0", dmem_req, dmem_be, dmem_wdata, stall_o);
    end
    step();
    drive(NOP, 0, 0, 0); dmem_ready = 1'b0;
    #1;
    n_checks++;
    if ({instr_4, data_4, csrdata_4, dmem_req} !== {SH, 32'h2002, 32'h22, 1'b0}) begin
      n_fail++;
      $display("FAIL sh_retire: got %h %h %h req=%b want %h 2002 22 0", instr_4, data_4, csrdata_4, dmem_req, SH);
    end
  endtask

  task automatic test_store_byte();
    drive(SB, 32'h5003, 32'h000000A7, 0); dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, dmem_addr, dmem_be, dmem_wdata, stall_o} !== {1'b1, 32'h5000, 4'b1000, 32'hA7A7A7A7, 1'b0}) begin
      n_fail++;
      $display("FAIL sb_lanes: req=%b addr=%h be=%b wdata=%h stall=%b", dmem_req, dmem_addr, dmem_be, dmem_wdata, stall_o);
    end
    step();
    drive(NOP, 0, 0, 0); dmem_ready = 1'b0;
    n_checks++;
    if ({instr_4, data_4} !== {SB, 32'h5003}) begin
      n_fail++;
      $display("FAIL sb_retire: got %h %h want %h 5003", instr_4, data_4, SB);
    end
  endtask

  task automatic test_misalign();
    drive(LW, 32'h3001, 0, 0); dmem_ready = 1'b1;
    #1;
    n_checks++;
    if ({dmem_req, stall_o} !== 2'b00) begin
      n_fail++;
      $display("FAIL lw_mis_noreq: req=%b stall=%b want 0 0", dmem_req, stall_o);
    end
    step();
    drive(ADDI, 32'h5, 0, 0); dmem_ready = 1'b0;
    n_checks++;
    if ({misalign_o, instr_4} !== {1'b1, NOP}) begin
      n_fail++;
      $display("FAIL lw_mis_pulse: mis=%b instr_4=%h want 1 %h", misalign_o, instr_4, NOP);
    end
    step();
    drive(NOP, 0, 0, 0);
    n_checks++;
    if ({misalign_o, instr_4, data_4} !== {1'b0, ADDI, 32'h5}) begin
      n_fail++;
      $display("FAIL lw_mis_next: mis=%b instr_4=%h data_4=%h want 0 %h 5", misalign_o, instr_4, data_4, ADDI);
    end
  endtask

  task automatic test_lhu();
    drive(LHU, 32'h4002, 0, 0); dmem_ready = 1'b1;
    step();
    dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h8001FFFF;
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL lhu_stall: stall=%b want 0", stall_o);
    end
    step();
    dmem_rvalid = 1'b0; drive(NOP, 0, 0, 0);
    n_checks++;
    if ({instr_4, data_4} !== {LHU, 32'h00008001}) begin
      n_fail++;
      $display("FAIL lhu_result: got %h %h want %h 00008001", instr_4, data_4, LHU);
    end
  endtask

  initial begin
    test_reset();
    test_passthru();
    test_load_latency();
    test_store_backpressure();
    test_store_byte();
    test_misalign();
    test_lhu();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stage4.md
Name: stage4

Overview:
- Memory-access stage of the RV32I 5-stage pipeline.
- Sits between execute (stage3) and writeback (stage5).
- Issues loads and stores to data memory over a valid/ready request channel with variable-latency read responses.
- Aligns and sign-extends load data, stalls upstream while memory is busy, and registers instr_4/data_4/csrdata_4 for writeback.

Parameters:
- NOP_INSTR, 32'h00000013, bubble instruction (addi x0,x0,0) placed in instr_4 when no instruction retires.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- instr_3  input  32  instruction from execute
- alu_3  input  32  ALU result (effective address for load/store)
- rs2data_3  input  32  store data
- csrdata_3  input  32  CSR data from execute
- stall_o  output  1  upstream must hold stage3 outputs while high
- dmem_req  output  1  memory request valid
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address ({alu_3[31:2],2'b00})
- dmem_be  output  4  byte enables
- dmem_wdata  output  32  lane-shifted store data
- dmem_ready  input  1  request accepted this cycle
- dmem_rvalid  input  1  load response valid
- dmem_rdata  input  32  load response word
- misalign_o  output  1  one-cycle pulse: misaligned access dropped
- instr_4  output  32  registered instruction to writeback
- data_4  output  32  registered result (load data or ALU result)
- csrdata_4  output  32  registered CSR data

Behaviour:
- Reset values: instr_4=NOP_INSTR, data_4=0, csrdata_4=0, misalign_o=0. FSM goes to IDLE.
- Reset mid-transaction returns to IDLE. Any dmem_rvalid arriving while IDLE is ignored.
- Decode: opcode=instr_3[6:2], funct3=instr_3[14:12], off=alu_3[1:0].
  - LOAD = 00000.
  - STORE = 01000.
  - Everything else is non-memory.
- FSM states: IDLE, REQ, WAIT.
- IDLE, non-memory instruction: stage register loads instr_3, alu_3, csrdata_3 at the clock edge. Zero added latency; stall_o=0.
- IDLE, load/store, aligned:
  - dmem_req=1 combinationally in the same cycle.
  - If dmem_ready=0: go to REQ.
  - Store with dmem_ready=1: retires this cycle (stage register loads instr_3, data_4=alu_3), no stall.
  - Load with dmem_ready=1: go to WAIT.
- REQ: dmem_req held with stable addr/be/wdata until dmem_ready. Then a store retires; a load goes to WAIT.
- WAIT: dmem_req=0. On dmem_rvalid: data_4 = formatted load, instr_4 = instr_3, return to IDLE.
  - dmem_rvalid in the same cycle as acceptance is not possible. A response is counted only from the cycle after acceptance.
- stall_o = (IDLE and memory op and not(store and dmem_ready)) or REQ or (WAIT and not dmem_rvalid).
- Any cycle stall_o=1 loads instr_4=NOP_INSTR; data_4 and csrdata_4 hold their values.
- Misalignment is defined as:
  - lh/lhu/sh with off[0]=1, or
  - lw/sw with off≠0.
- On misalignment: no dmem_req, instr_4=NOP_INSTR, misalign_o=1 for one cycle, no stall. The instruction is dropped.
- Store lanes, by funct3:
  - sb (000): be = 4'b0001<<off, wdata = {4{rs2[7:0]}}.
  - sh (001): be = 4'b0011<<off, wdata = {2{rs2[15:0]}}.
  - sw (010): be = 4'b1111, wdata = rs2.
- Load format: byte = rdata>>(8*off).
  - lb (000) sign-extends [7:0].
  - lh (001) sign-extends [15:0].
  - lw (010) takes the full word.
  - lbu (100) zero-extends [7:0].
  - lhu (101) zero-extends [15:0].
  - Other funct3 values yield 0.
- csrdata_4 always follows csrdata_3 on any retiring instruction.

Decomposition:
- rv32_pkg holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_LUI, …);
  - funct3 load/store constants;
  - NOP_INSTR;
  - the mem_state_t enum {IDLE, REQ, WAIT}.
- One combinational sub-module, load_align: inputs rdata, off, funct3; output the formatted 32-bit word.
- Store lane generation stays inline.

Test Plan:
- Reset behaviour: assert reset for 2 cycles mid-WAIT, then deassert with no instruction pending → instr_4=32'h00000013, data_4=0, dmem_req=0. A late dmem_rvalid=1 that arrives while IDLE is ignored.
- Non-memory pass-through: addi instr_3=32'h00500093 with alu_3=5 → next cycle instr_4=32'h00500093, data_4=5, stall_o=0 throughout.
- Load with latency: lb with alu_3=32'h1002, dmem_ready=1 in the first cycle, dmem_rvalid 3 cycles later with rdata=32'h12F04455.
  - Required: dmem_addr=32'h1000.
  - Required: data_4=32'hFFFFFFF0.
  - Required: stall_o high for 3 cycles, and instr_4 is NOP during the stall.
- Store with backpressure: sh, alu_3=32'h2002, rs2=32'hABCD1234, dmem_ready low for 2 cycles.
  - Required: be=4'b1100 and wdata=32'h12341234, held stable.
  - Required: stall_o=1 for 2 cycles; the store retires on the cycle ready rises.
- Misaligned word: lw with alu_3=32'h3001 → no dmem_req, misalign_o pulses once, instr_4=NOP, and the next instruction flows normally.
- Unsigned half load: lhu with off=2 and rdata=32'h8001FFFF → data_4=32'h00008001.
